// File: rtl/mlp_weight_bank.sv
// mlp_weight_bank
// ---------------------------------------------------------------------------
// Multi-bank weight store for the MLP datapath. One bank of DEPTH signed
// weights per neuron. The host fills the banks through a random-access write
// port. On request, all banks are streamed in parallel, one word address per
// beat, to the MAC array over a valid/ready handshake. After every reset a
// self-clearing sweep zeroes all storage, so no location ever reads as X.
//
// Ports
//   clk           single clock, rising edge
//   rst           synchronous active-high reset
//   wr_en         host write strobe
//   wr_bank       target bank of the write
//   wr_addr       target word of the write
//   wr_data       write data
//   wr_err        one-cycle pulse: the previous-cycle write was dropped
//   stream_start  request a full read-out (sampled only in IDLE)
//   stream_ready  consumer accepts the current beat
//   rd_valid      rd_data holds a valid beat
//   rd_data       bank b at bits [b*DATA_WIDTH +: DATA_WIDTH]
//   rd_addr       word index of the current beat
//   rd_last       current beat is word DEPTH-1
//   busy          high while clearing or streaming
// ---------------------------------------------------------------------------
module mlp_weight_bank #(
   parameter int NUM_BANKS  = 4,
   parameter int ADDR_WIDTH = 2,
   parameter int DEPTH      = 3,
   parameter int DATA_WIDTH = 16,
   parameter int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            wr_en,
   input  logic [BANK_W-1:0]               wr_bank,
   input  logic [ADDR_WIDTH-1:0]           wr_addr,
   input  logic signed [DATA_WIDTH-1:0]    wr_data,
   output logic                            wr_err,
   input  logic                            stream_start,
   input  logic                            stream_ready,
   output logic                            rd_valid,
   output logic [NUM_BANKS*DATA_WIDTH-1:0] rd_data,
   output logic [ADDR_WIDTH-1:0]           rd_addr,
   output logic                            rd_last,
   output logic                            busy
);

   localparam logic [1:0] ST_CLEAR  = 2'd0;
   localparam logic [1:0] ST_IDLE   = 2'd1;
   localparam logic [1:0] ST_STREAM = 2'd2;

   // The read pointer needs one extra bit so it can sit at DEPTH (all words
   // issued) even when DEPTH fills the whole address space.
   localparam int                    PTR_W     = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [PTR_W-1:0]      DEPTH_P   = PTR_W'(DEPTH);
   localparam logic [BANK_W:0]       BANKS_P   = (BANK_W + 1)'(NUM_BANKS);

   logic [1:0]                     state;
   logic [ADDR_WIDTH-1:0]          clr_ptr;
   logic [PTR_W-1:0]               rd_ptr;
   logic signed [DATA_WIDTH-1:0]   mem [NUM_BANKS][DEPTH];
   logic [NUM_BANKS*DATA_WIDTH-1:0] rd_word;

   logic wr_in_range;
   logic wr_accept;
   logic rd_has_word;
   logic load;
   logic handshake;

   // Range checks are done one bit wider so they stay meaningful even when
   // the field width exactly covers NUM_BANKS or DEPTH.
   assign wr_in_range = ({1'b0, wr_bank} < BANKS_P) && ({1'b0, wr_addr} < DEPTH_P);
   assign wr_accept   = wr_en && wr_in_range && (state == ST_IDLE) && !rst;

   assign rd_has_word = (rd_ptr < DEPTH_P);
   // Output register refills when empty or when its beat is being consumed,
   // which gives full throughput without a combinational ready->valid path.
   assign load        = (state == ST_STREAM) && (!rd_valid || stream_ready) && rd_has_word;
   assign handshake   = rd_valid && stream_ready;

   assign busy = (state != ST_IDLE);

   // Gather the current word of every bank into one wide beat. rd_ptr's low
   // bits are always a legal index whenever load can fire.
   always_comb begin
      rd_word = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         rd_word[b*DATA_WIDTH +: DATA_WIDTH] = mem[b][rd_ptr[ADDR_WIDTH-1:0]];
      end
   end

   // Storage: not reset directly; the CLEAR sweep zeroes every word. A write
   // accepted on the same edge as stream_start lands before the first read.
   always_ff @(posedge clk) begin
      if (state == ST_CLEAR) begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            mem[b][clr_ptr] <= '0;
         end
      end else if (wr_accept) begin
         mem[wr_bank][wr_addr] <= wr_data;
      end
   end

   // Control and output beat register
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_CLEAR;
         clr_ptr  <= '0;
         rd_ptr   <= '0;
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
         rd_addr  <= '0;
         rd_data  <= '0;
         wr_err   <= 1'b0;
      end else begin
         // Any write that was not taken (out of range or wrong state) is
         // reported one cycle later.
         wr_err <= wr_en && !wr_accept;

         case (state)
            ST_CLEAR: begin
               if (clr_ptr == LAST_ADDR) begin
                  state   <= ST_IDLE;
                  clr_ptr <= '0;
               end else begin
                  clr_ptr <= clr_ptr + 1'b1;
               end
            end

            ST_IDLE: begin
               if (stream_start) begin
                  state  <= ST_STREAM;
                  rd_ptr <= '0;
               end
            end

            ST_STREAM: begin
               if (load) begin
                  rd_data  <= rd_word;
                  rd_addr  <= rd_ptr[ADDR_WIDTH-1:0];
                  rd_last  <= (rd_ptr[ADDR_WIDTH-1:0] == LAST_ADDR);
                  rd_valid <= 1'b1;
                  rd_ptr   <= rd_ptr + 1'b1;
               end else if (handshake) begin
                  // Only the final beat can be consumed without a refill.
                  rd_valid <= 1'b0;
                  rd_last  <= 1'b0;
                  if (rd_last) begin
                     state <= ST_IDLE;
                  end
               end
            end

            default: begin
               state <= ST_CLEAR;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mlp_weight_bank.sv
// Testbench for mlp_weight_bank: directed scenarios plus randomized writes
// and randomized consumer backpressure, checked against an array model of
// the weight banks.
module tb_mlp_weight_bank;

   localparam int NB  = 4;
   localparam int AW  = 2;
   localparam int DEP = 3;
   localparam int DW  = 16;
   localparam int BW  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              wr_en;
   logic [BW-1:0]     wr_bank;
   logic [AW-1:0]     wr_addr;
   logic [DW-1:0]     wr_data;
   logic              wr_err;
   logic              stream_start;
   logic              stream_ready;
   logic              rd_valid;
   logic [NB*DW-1:0]  rd_data;
   logic [AW-1:0]     rd_addr;
   logic              rd_last;
   logic              busy;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0]    model [NB][DEP];
   logic [NB*DW-1:0] seen  [DEP];

   mlp_weight_bank #(
      .NUM_BANKS(NB), .ADDR_WIDTH(AW), .DEPTH(DEP), .DATA_WIDTH(DW)
   ) dut (
      .clk(clk), .rst(rst),
      .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_err(wr_err),
      .stream_start(stream_start), .stream_ready(stream_ready),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_addr(rd_addr),
      .rd_last(rd_last), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      for (int b = 0; b < NB; b++)
         for (int a = 0; a < DEP; a++)
            model[b][a] = '0;
   endtask

   function automatic logic [NB*DW-1:0] exp_word(input int a);
      logic [NB*DW-1:0] w;
      w = '0;
      for (int b = 0; b < NB; b++) w[b*DW +: DW] = model[b][a];
      return w;
   endfunction

   // Host write while the block is known to be idle; the model decides
   // whether it should be taken.
   task automatic do_write(input int b, input int a, input logic [DW-1:0] d);
      bit ok;
      ok = (b < NB) && (a < DEP);
      wr_en = 1'b1; wr_bank = BW'(b); wr_addr = AW'(a); wr_data = d;
      tick();
      wr_en = 1'b0;
      if (ok) model[b][a] = d;
      checks++;
      if (wr_err !== !ok) begin
         errors++;
         $display("FAIL wr_err_pulse b=%0d a=%0d: got %b expected %b", b, a, wr_err, !ok);
      end
      tick();
      checks++;
      if (wr_err !== 1'b0) begin
         errors++;
         $display("FAIL wr_err_clears b=%0d a=%0d: got %b expected 0", b, a, wr_err);
      end
   endtask

   // Start a stream (optionally with a same-edge write) and consume it,
   // checking every beat against the model.
   task automatic run_stream(input string tag, input int stall_addr, input int stall_len,
                             input bit rnd, input bit with_wr, input int wb, input int wa,
                             input logic [DW-1:0] wd);
      int beats = 0;
      int cyc = 0;
      int exp_a = 0;
      int stalled = 0;
      logic pv = 1'b0;
      logic pr = 1'b0;
      logic r;
      logic [NB*DW-1:0] pd = '0;
      logic [AW-1:0] pa = '0;
      if (with_wr) begin
         wr_en = 1'b1; wr_bank = BW'(wb); wr_addr = AW'(wa); wr_data = wd;
         model[wb][wa] = wd;
      end
      stream_start = 1'b1; stream_ready = 1'b0;
      tick();
      stream_start = 1'b0; wr_en = 1'b0;
      if (with_wr) begin
         checks++;
         if (wr_err !== 1'b0) begin
            errors++;
            $display("FAIL %s same_edge_wr_err: got %b expected 0", tag, wr_err);
         end
      end
      while (beats < DEP && cyc < 60) begin
         if (cyc == 0) begin
            checks++;
            if (rd_valid !== 1'b0 || busy !== 1'b1) begin
               errors++;
               $display("FAIL %s start_latency: valid=%b busy=%b expected valid=0 busy=1", tag, rd_valid, busy);
            end
         end
         if (cyc == 1) begin
            checks++;
            if (rd_valid !== 1'b1) begin
               errors++;
               $display("FAIL %s first_beat: valid=%b expected 1", tag, rd_valid);
            end
         end
         if (pv && !pr) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== pd || rd_addr !== pa) begin
               errors++;
               $display("FAIL %s hold_stable: valid=%b addr=%0d data=%h expected 1 %0d %h",
                        tag, rd_valid, rd_addr, rd_data, pa, pd);
            end
         end
         if (rd_valid === 1'b1) begin
            checks++;
            if (rd_addr !== AW'(exp_a) || rd_data !== exp_word(exp_a) ||
                rd_last !== (exp_a == DEP - 1) || busy !== 1'b1) begin
               errors++;
               $display("FAIL %s beat: addr=%0d data=%h last=%b busy=%b expected %0d %h %b 1",
                        tag, rd_addr, rd_data, rd_last, busy, exp_a, exp_word(exp_a), exp_a == DEP - 1);
            end
         end
         if (rnd) r = 1'($urandom_range(0, 1));
         else if (rd_valid && rd_addr == AW'(stall_addr) && stall_addr >= 0 && stalled < stall_len) begin
            r = 1'b0; stalled++;
         end else r = 1'b1;
         stream_ready = r;
         pv = rd_valid; pr = r; pd = rd_data; pa = rd_addr;
         if (rd_valid && r) begin
            seen[exp_a] = rd_data;
            beats++; exp_a++;
         end
         tick();
         cyc++;
      end
      stream_ready = 1'b0;
      checks++;
      if (beats != DEP) begin
         errors++;
         $display("FAIL %s beat_count: got %0d expected %0d", tag, beats, DEP);
      end
      checks++;
      if (rd_valid !== 1'b0 || busy !== 1'b0 || rd_last !== 1'b0) begin
         errors++;
         $display("FAIL %s stream_end: valid=%b busy=%b last=%b expected 0 0 0", tag, rd_valid, busy, rd_last);
      end
      if (stall_len == 0 && !rnd) begin
         checks++;
         if (cyc != DEP + 1) begin
            errors++;
            $display("FAIL %s throughput: took %0d cycles expected %0d", tag, cyc, DEP + 1);
         end
      end
   endtask

   task automatic wait_clear(input string tag);
      for (int i = 0; i < DEP; i++) begin
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s clear_busy cycle %0d: got %b expected 1", tag, i, busy);
         end
         tick();
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s clear_done: busy=%b expected 0", tag, busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      checks++;
      if (rd_valid !== 1'b0 || rd_last !== 1'b0 || rd_addr !== '0 ||
          rd_data !== '0 || wr_err !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_values: valid=%b last=%b addr=%0d data=%h err=%b busy=%b",
                  rd_valid, rd_last, rd_addr, rd_data, wr_err, busy);
      end
      rst = 1'b0;
      clear_model();
      wait_clear("reset");
      run_stream("reset_zero", -1, 0, 1'b0, 1'b0, 0, 0, '0);
   endtask

   task automatic test_load_stream();
      for (int b = 0; b < NB; b++)
         for (int a = 0; a < DEP; a++)
            do_write(b, a, {4'(b), 4'(a), 4'(b), 4'(a)});
      run_stream("load", -1, 0, 1'b0, 1'b0, 0, 0, '0);
      checks++;
      if (seen[1] !== 64'h3131_2121_1111_0101) begin
         errors++;
         $display("FAIL load_addr1: got %h expected 3131212111110101", seen[1]);
      end
   endtask

   task automatic test_backpressure();
      run_stream("backpressure", 1, 4, 1'b0, 1'b0, 0, 0, '0);
   endtask

   task automatic test_dropped_writes();
      do_write(1, 3, 16'h5A5A);
      run_stream("drop_range", -1, 0, 1'b0, 1'b0, 0, 0, '0);
      // Write during the last clear cycle must be dropped.
      rst = 1'b1; tick(); rst = 1'b0;
      clear_model();
      tick(); tick();
      wr_en = 1'b1; wr_bank = '0; wr_addr = '0; wr_data = 16'hDEAD;
      tick();
      wr_en = 1'b0;
      checks++;
      if (wr_err !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL drop_busy: wr_err=%b busy=%b expected 1 0", wr_err, busy);
      end
      tick();
      checks++;
      if (wr_err !== 1'b0) begin
         errors++;
         $display("FAIL drop_busy_pulse: wr_err=%b expected 0", wr_err);
      end
      run_stream("drop_busy", -1, 0, 1'b0, 1'b0, 0, 0, '0);
   endtask

   task automatic test_reset_mid_stream();
      do_write(3, 2, 16'h1234);
      do_write(0, 0, 16'h8001);
      stream_start = 1'b1; tick(); stream_start = 1'b0;
      stream_ready = 1'b1;
      tick();
      checks++;
      if (rd_valid !== 1'b1 || rd_addr !== '0 || rd_data !== exp_word(0)) begin
         errors++;
         $display("FAIL midrst_first_beat: valid=%b addr=%0d data=%h", rd_valid, rd_addr, rd_data);
      end
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; stream_ready = 1'b0;
      checks++;
      if (rd_valid !== 1'b0 || busy !== 1'b1 || rd_data !== '0) begin
         errors++;
         $display("FAIL midrst_abort: valid=%b busy=%b data=%h expected 0 1 0", rd_valid, busy, rd_data);
      end
      clear_model();
      wait_clear("midrst");
      run_stream("midrst_zero", -1, 0, 1'b0, 1'b0, 0, 0, '0);
   endtask

   task automatic test_same_edge();
      run_stream("same_edge", -1, 0, 1'b0, 1'b1, 2, 0, 16'hBEEF);
      checks++;
      if (seen[0][47:32] !== 16'hBEEF) begin
         errors++;
         $display("FAIL same_edge_data: got %h expected beef", seen[0][47:32]);
      end
   endtask

   task automatic test_back_to_back();
      run_stream("b2b_first", -1, 0, 1'b0, 1'b0, 0, 0, '0);
      run_stream("b2b_second", -1, 0, 1'b0, 1'b0, 0, 0, '0);
   endtask

   task automatic test_random();
      for (int round = 0; round < 5; round++) begin
         for (int i = 0; i < 6; i++)
            do_write(int'($urandom_range(0, NB - 1)), int'($urandom_range(0, 3)), DW'($urandom));
         run_stream("random", -1, 0, 1'b1, 1'b0, 0, 0, '0);
      end
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_bank = '0; wr_addr = '0; wr_data = '0;
      stream_start = 1'b0; stream_ready = 1'b0;
      test_reset();
      test_load_stream();
      test_backpressure();
      test_dropped_writes();
      test_same_edge();
      test_back_to_back();
      test_reset_mid_stream();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mlp_weight_bank.md
# mlp_weight_bank

Multi-bank weight store for the MLP datapath, successor to the single-port weight memory. It holds one bank of `DEPTH` weights per neuron. The host loads the banks through a random-access write port. On request, the block streams all banks in parallel, one address per beat, to the MAC array over a valid/ready handshake. After every reset it runs a self-clearing sweep, so no location ever reads as X.

## Interface
- `NUM_BANKS`, default 4: number of banks (neurons); ≥1.
- `ADDR_WIDTH`, default 2: word address width per bank ($clog2(2+1) for the current case study).
- `DEPTH`, default 3: words used per bank; 1 ≤ DEPTH ≤ 2^ADDR_WIDTH.
- `DATA_WIDTH`, default 16: weight width (Q-format signed, opaque to this block).
- `BANK_W`, derived: max($clog2(NUM_BANKS),1).

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  write strobe.
- `wr_bank`  in  BANK_W  target bank.
- `wr_addr`  in  ADDR_WIDTH  target word.
- `wr_data`  in  DATA_WIDTH  write data.
- `wr_err`  out  1  one-cycle pulse: previous-cycle write was dropped.
- `stream_start`  in  1  request a full read-out; sampled only in IDLE.
- `stream_ready`  in  1  consumer accepts the current beat.
- `rd_valid`  out  1  `rd_data` holds a valid beat.
- `rd_data`  out  NUM_BANKS*DATA_WIDTH  bank b at bits [b*DATA_WIDTH +: DATA_WIDTH].
- `rd_addr`  out  ADDR_WIDTH  word index of the current beat.
- `rd_last`  out  1  current beat is address DEPTH-1.
- `busy`  out  1  high in CLEAR or STREAM.

## Operation
- FSM states: CLEAR, IDLE, STREAM.
- Storage: `NUM_BANKS` × `DEPTH` registers/BRAM words.
- Reset values:
  - state = CLEAR, clear pointer = 0, busy = 1.
  - rd_valid = 0, rd_last = 0, rd_addr = 0, rd_data = 0, wr_err = 0.
  - Memory contents are not reset directly; the clear sweep zeroes them.
- CLEAR:
  - Each cycle, writes 0 to address `clr_ptr` in every bank, then increments `clr_ptr`.
  - After writing DEPTH-1, goes to IDLE.
- IDLE:
  - A write is accepted when wr_en=1, wr_bank<NUM_BANKS and wr_addr<DEPTH.
  - A write with wr_en=1 is dropped if it is out of range, or if state≠IDLE. A dropped write pulses wr_err on the next cycle.
  - stream_start=1 goes to STREAM with read pointer = 0. If wr_en and stream_start are both asserted, the write is performed and the stream starts; the stream sees the new data.
- STREAM:
  - The output register loads mem[*][ptr] when (!rd_valid || stream_ready) and ptr<DEPTH. Each load sets rd_valid=1, rd_addr=ptr, rd_last=(ptr==DEPTH-1), and increments ptr.
  - A handshake happens when rd_valid && stream_ready.
  - While rd_valid=1 and stream_ready=0, rd_data, rd_addr and rd_last hold stable.
  - When the beat with rd_last is accepted: rd_valid→0, rd_last→0, state→IDLE.
- stream_start outside IDLE is ignored; it is not queued.
- rst asserted in any state, including mid-stream, aborts the current operation and applies the reset values on that edge. The clear sweep then restarts and all previously loaded weights are lost.

## Timing
- Clear sweep: rst low at edge 0 gives clear writes at edges 1..DEPTH. busy=1 through edge DEPTH; IDLE and busy=0 after edge DEPTH.
- Write latency: data written at the sampling edge; visible to a stream started on the same edge.
- wr_err: pulses exactly one cycle, on the edge after the offending write.
- Stream latency: stream_start sampled at edge t gives first beat valid after edge t+1 (1-cycle synchronous read).
- Throughput: with stream_ready held high, one beat per cycle, DEPTH consecutive beats. rd_valid falls after edge t+DEPTH+1; busy falls on the same edge.
- Back-to-back: a new stream_start is accepted on the edge after IDLE is re-entered.
- No combinational path from stream_ready to rd_valid or rd_data.

## Test plan
- Reset/clear: hold rst 2 cycles, release, then start a stream with ready=1. Required: busy=1 for 3 cycles after release, then 3 beats, all with rd_data=64'h0, rd_addr 0,1,2, rd_last only on addr 2.
- Load/stream:
  - Write bank b, addr a with value 16'h{b}{a}{b}{a} for all 12 locations.
  - Start a stream with ready=1.
  - Required: beat at addr 1 = 64'h3131_2121_1111_0101; 3 consecutive beats; busy drops on the same edge as rd_valid.
- Backpressure: during a stream, hold ready=0 for 4 cycles on beat addr 1. Required: rd_data and rd_addr stay stable, no beat is lost or duplicated, and 3 beats are accepted in total.
- Dropped writes:
  - Write to wr_addr=3 (≥DEPTH): wr_err=1 for one cycle, no location changes.
  - Write 16'hDEAD to bank 0 addr 0 while busy: wr_err=1, and a later stream shows the old value.
- Reset mid-stream: assert rst after the first beat. Required: rd_valid=0 the next cycle, the clear sweep reruns, and a subsequent stream returns all zeros.
- Same-edge write+start: wr_en with 16'hBEEF to bank 2 addr 0, together with stream_start. Required: the first beat has bits [47:32]=16'hBEEF and wr_err=0.
